// File: rtl/axi_arbiter_if.sv
// Shared AXI bus bundle: 32-bit address/data, 4-bit ID, all five channels.
// The arbiter's upstream ports use the slave view; its downstream port uses the master view.
interface axi_if;
  logic        arvalid;
  logic        arready;
  logic [31:0] araddr;
  logic [3:0]  arid;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;

  logic        rvalid;
  logic        rready;
  logic [31:0] rdata;
  logic [3:0]  rid;
  logic [1:0]  rresp;
  logic        rlast;

  logic        awvalid;
  logic        awready;
  logic [31:0] awaddr;
  logic [3:0]  awid;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;

  logic        wvalid;
  logic        wready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;

  logic        bvalid;
  logic        bready;
  logic [3:0]  bid;
  logic [1:0]  bresp;

  modport master (
    output arvalid, araddr, arid, arlen, arsize, arburst,
    input  arready,
    input  rvalid, rdata, rid, rresp, rlast,
    output rready,
    output awvalid, awaddr, awid, awlen, awsize, awburst,
    input  awready,
    output wvalid, wdata, wstrb, wlast,
    input  wready,
    input  bvalid, bid, bresp,
    output bready
  );

  modport slave (
    input  arvalid, araddr, arid, arlen, arsize, arburst,
    output arready,
    output rvalid, rdata, rid, rresp, rlast,
    input  rready,
    input  awvalid, awaddr, awid, awlen, awsize, awburst,
    output awready,
    input  wvalid, wdata, wstrb, wlast,
    output wready,
    output bvalid, bid, bresp,
    input  bready
  );
endinterface

// File: rtl/axi_arbiter.sv
// Two-master, one-slave AXI arbiter: one whole transaction at a time, round-robin
// between masters, read preferred over write within the winning master.
module axi_arbiter (
  input logic   clk,
  input logic   rst,
  axi_if.slave  m0,
  axi_if.slave  m1,
  axi_if.master s
);

  typedef enum logic [2:0] {IDLE, RD0, RD1, WR0, WR1} state_e;

  state_e state_q, state_d;
  logic   last_q, last_d;
  logic   req0, req1, win, winRd;
  logic   rdOwn0, rdOwn1, wrOwn0, wrOwn1;

  assign rdOwn0 = (state_q == RD0);
  assign rdOwn1 = (state_q == RD1);
  assign wrOwn0 = (state_q == WR0);
  assign wrOwn1 = (state_q == WR1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Under contention the master that was not granted last time wins.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    req0    = m0.arvalid | m0.awvalid;
    req1    = m1.arvalid | m1.awvalid;
    win     = (req0 && req1) ? ~last_q : req1;
    winRd   = win ? m1.arvalid : m0.arvalid;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          state_d = winRd ? (win ? RD1 : RD0) : (win ? WR1 : WR0);
          last_d  = win;
        end
      end
      RD0, RD1: begin
        if (s.rvalid && s.rready && s.rlast) state_d = IDLE;
      end
      WR0, WR1: begin
        if (s.bvalid && s.bready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream side: only the owning master's channel group is forwarded.
  always_comb begin
    s.arvalid = 1'b0;
    s.araddr  = '0;
    s.arid    = '0;
    s.arlen   = '0;
    s.arsize  = '0;
    s.arburst = '0;
    s.rready  = 1'b0;
    s.awvalid = 1'b0;
    s.awaddr  = '0;
    s.awid    = '0;
    s.awlen   = '0;
    s.awsize  = '0;
    s.awburst = '0;
    s.wvalid  = 1'b0;
    s.wdata   = '0;
    s.wstrb   = '0;
    s.wlast   = 1'b0;
    s.bready  = 1'b0;
    if (rdOwn0) begin
      s.arvalid = m0.arvalid;
      s.araddr  = m0.araddr;
      s.arid    = m0.arid;
      s.arlen   = m0.arlen;
      s.arsize  = m0.arsize;
      s.arburst = m0.arburst;
      s.rready  = m0.rready;
    end else if (rdOwn1) begin
      s.arvalid = m1.arvalid;
      s.araddr  = m1.araddr;
      s.arid    = m1.arid;
      s.arlen   = m1.arlen;
      s.arsize  = m1.arsize;
      s.arburst = m1.arburst;
      s.rready  = m1.rready;
    end
    if (wrOwn0) begin
      s.awvalid = m0.awvalid;
      s.awaddr  = m0.awaddr;
      s.awid    = m0.awid;
      s.awlen   = m0.awlen;
      s.awsize  = m0.awsize;
      s.awburst = m0.awburst;
      s.wvalid  = m0.wvalid;
      s.wdata   = m0.wdata;
      s.wstrb   = m0.wstrb;
      s.wlast   = m0.wlast;
      s.bready  = m0.bready;
    end else if (wrOwn1) begin
      s.awvalid = m1.awvalid;
      s.awaddr  = m1.awaddr;
      s.awid    = m1.awid;
      s.awlen   = m1.awlen;
      s.awsize  = m1.awsize;
      s.awburst = m1.awburst;
      s.wvalid  = m1.wvalid;
      s.wdata   = m1.wdata;
      s.wstrb   = m1.wstrb;
      s.wlast   = m1.wlast;
      s.bready  = m1.bready;
    end
  end

  // Upstream side: the non-owner sees all zeros, so a loser simply holds its valid.
  always_comb begin
    m0.arready = 1'b0;
    m0.rvalid  = 1'b0;
    m0.rdata   = '0;
    m0.rid     = '0;
    m0.rresp   = '0;
    m0.rlast   = 1'b0;
    m0.awready = 1'b0;
    m0.wready  = 1'b0;
    m0.bvalid  = 1'b0;
    m0.bid     = '0;
    m0.bresp   = '0;
    m1.arready = 1'b0;
    m1.rvalid  = 1'b0;
    m1.rdata   = '0;
    m1.rid     = '0;
    m1.rresp   = '0;
    m1.rlast   = 1'b0;
    m1.awready = 1'b0;
    m1.wready  = 1'b0;
    m1.bvalid  = 1'b0;
    m1.bid     = '0;
    m1.bresp   = '0;
    if (rdOwn0) begin
      m0.arready = s.arready;
      m0.rvalid  = s.rvalid;
      m0.rdata   = s.rdata;
      m0.rid     = s.rid;
      m0.rresp   = s.rresp;
      m0.rlast   = s.rlast;
    end
    if (rdOwn1) begin
      m1.arready = s.arready;
      m1.rvalid  = s.rvalid;
      m1.rdata   = s.rdata;
      m1.rid     = s.rid;
      m1.rresp   = s.rresp;
      m1.rlast   = s.rlast;
    end
    if (wrOwn0) begin
      m0.awready = s.awready;
      m0.wready  = s.wready;
      m0.bvalid  = s.bvalid;
      m0.bid     = s.bid;
      m0.bresp   = s.bresp;
    end
    if (wrOwn1) begin
      m1.awready = s.awready;
      m1.wready  = s.wready;
      m1.bvalid  = s.bvalid;
      m1.bid     = s.bid;
      m1.bresp   = s.bresp;
    end
  end

endmodule
